// File: rtl/reflet_ram_narrow_responder.sv
// Narrow (8/16/32-bit) load/store responder in front of a wide single-port synchronous RAM.
// Optional REFLET_RAM_RESP_MISALIGN_ERR_EN rejects misaligned accesses with resp_err.
module reflet_ram_narrow_responder #(
  parameter int unsigned wordsize       = 16,
  parameter int unsigned ram_addr_width = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic [wordsize-1:0]       req_addr,
  input  logic [wordsize-1:0]       req_wdata,
  output logic                      resp_valid,
  output logic [wordsize-1:0]       resp_rdata,
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
  output logic                      resp_err,
`endif
  output logic [ram_addr_width-1:0] ram_addr,
  output logic                      ram_we,
  output logic [wordsize-1:0]       ram_wdata,
  input  logic [wordsize-1:0]       ram_rdata
);

  localparam int unsigned Bytes   = wordsize / 8;
  localparam int unsigned OffBits = $clog2(Bytes);
  localparam int unsigned OffW    = (OffBits == 0) ? 1 : OffBits;
  localparam int unsigned ExtW    = (wordsize > ram_addr_width) ? wordsize : ram_addr_width;

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  // Sizes wider than the RAM word collapse to a full-word access.
  function automatic int unsigned width_bits(input logic [1:0] size);
    int unsigned w;
    case (size)
      2'b01:   w = 32;
      2'b10:   w = 16;
      2'b11:   w = 8;
      default: w = wordsize;
    endcase
    if (w > wordsize) w = wordsize;
    return w;
  endfunction

  function automatic logic [wordsize-1:0] lane_ones(input int unsigned w);
    logic [wordsize-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < wordsize; i++) m[i] = (i < w);
    return m;
  endfunction

  state_e                    state_q, state_d;
  logic                      write_q, write_d;
  logic [1:0]                size_q, size_d;
  logic [OffW-1:0]           off_q, off_d;
  logic [wordsize-1:0]       wdata_q, wdata_d;
  logic [wordsize-1:0]       merge_q, merge_d;
  logic [wordsize-1:0]       rdata_q, rdata_d;
  logic [ram_addr_width-1:0] ram_addr_q, ram_addr_d;
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
  logic                      err_q, err_d;
  logic                      req_mis;
`endif

  int unsigned               req_w;
  logic                      req_full;
  logic [OffW-1:0]           req_off;
  logic [OffW-1:0]           req_align;
  logic [OffW+2:0]           sh;
  logic [wordsize-1:0]       ones_q;
  logic [wordsize-1:0]       lane_q;

  always_comb begin
    req_w     = width_bits(req_size);
    req_full  = (req_w == wordsize);
    req_off   = OffW'(req_addr & wordsize'(Bytes - 1));
    req_align = OffW'(req_w / 8 - 1);
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
    req_mis   = (req_off & req_align) != '0;
`endif
    sh        = {off_q, 3'b000};
    ones_q    = lane_ones(width_bits(size_q));
    lane_q    = ones_q << sh;
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          off_d      = req_off & ~req_align;
          wdata_d    = req_wdata;
          ram_addr_d = ram_addr_width'(ExtW'(req_addr) >> OffBits);
          if (req_write && req_full) begin
            merge_d = req_wdata;
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
          if (req_mis) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        if (write_q) begin
          merge_d = (ram_rdata & ~lane_q) | ((wdata_q & ones_q) << sh);
          state_d = StWr;
        end else begin
          rdata_d = (ram_rdata >> sh) & ones_q;
          state_d = StResp;
        end
      end
      StWr: begin
        rdata_d = '0;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign ram_we     = (state_q == StWr);
  assign ram_wdata  = merge_q;
  assign ram_addr   = ram_addr_q;
  assign resp_rdata = rdata_q;
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
  assign resp_err   = err_q;
`endif

endmodule

// File: tb/tb_reflet_ram_narrow_responder.sv
// Bench for reflet_ram_narrow_responder: 32-bit instance driven from a vector table with a
// response scoreboard, plus a 16-bit instance for the full-width collapse case.
module tb_reflet_ram_narrow_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // 32-bit instance
  logic        req_valid, req_write, req_ready, resp_valid, ram_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, ram_wdata, ram_rdata;
  logic [11:0] ram_addr;
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
  logic        resp_err;
`endif
  logic [31:0] mem32 [0:4095];

  reflet_ram_narrow_responder #(.wordsize(32), .ram_addr_width(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
    .resp_err(resp_err),
`endif
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem32[ram_addr] <= ram_wdata;
    ram_rdata <= mem32[ram_addr];
  end

  // 16-bit instance
  logic        v16, w16, rdy16, rv16, we16;
  logic [1:0]  s16;
  logic [15:0] a16, wd16, rd16, rwd16, rrd16;
  logic [11:0] ra16;
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
  logic        err16;
`endif
  logic [15:0] mem16 [0:4095];

  reflet_ram_narrow_responder #(.wordsize(16), .ram_addr_width(12)) dut16 (
    .clk(clk), .reset(reset),
    .req_valid(v16), .req_ready(rdy16), .req_write(w16), .req_size(s16),
    .req_addr(a16), .req_wdata(wd16),
    .resp_valid(rv16), .resp_rdata(rd16),
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
    .resp_err(err16),
`endif
    .ram_addr(ra16), .ram_we(we16), .ram_wdata(rwd16), .ram_rdata(rrd16)
  );

  always @(posedge clk) begin
    if (we16) mem16[ra16] <= rwd16;
    rrd16 <= mem16[ra16];
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          we_lat;
    int          mem_idx;
    logic [31:0] mem_val;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic wr, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int lat, int we_lat, int mem_idx,
                              logic [31:0] mem_val, logic err);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.lat = lat; v.we_lat = we_lat; v.mem_idx = mem_idx; v.mem_val = mem_val; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, " ram_we"}, 64'(ram_we), 64'd0);
    chk({tag, " ram_addr"}, 64'(ram_addr), 64'd0);
    chk({tag, " resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({tag, " merge"}, 64'(ram_wdata), 64'd0);
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
    chk({tag, " resp_err"}, 64'(resp_err), 64'd0);
`endif
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int cyc;
    int we_cyc;
    logic seen;
    logic [31:0] held;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({nm, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size;
    req_addr = v.addr; req_wdata = v.wdata;
    e.rdata = v.rdata; e.lat = v.lat; e.err = v.err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; we_cyc = 0; seen = 1'b0; held = '0;
    while (!seen && cyc <= 20) begin
      if (ram_we && we_cyc == 0) we_cyc = cyc;
      if (resp_valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk({nm, " resp latency"}, 64'(cyc), 64'(e.lat));
        chk({nm, " resp_rdata"}, 64'(resp_rdata), 64'(e.rdata));
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
        chk({nm, " resp_err"}, 64'(resp_err), 64'(e.err));
`endif
        held = resp_rdata;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      chk({nm, " response timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    chk({nm, " ram_we cycle"}, 64'(we_cyc), 64'(v.we_lat));
    @(negedge clk);
    chk({nm, " resp_valid one-shot"}, 64'(resp_valid), 64'd0);
    chk({nm, " resp_rdata hold"}, 64'(resp_rdata), 64'(held));
    if (v.mem_idx >= 0) chk({nm, " ram word"}, 64'(mem32[v.mem_idx]), 64'(v.mem_val));
  endtask

  initial begin
    logic [9:0] rdy_log;
    logic [9:0] rv_log;
    int we_cyc;
    int rv_cyc;
    exp_t e;

    req_valid = 0; req_write = 0; req_size = 0; req_addr = 0; req_wdata = 0;
    v16 = 0; w16 = 0; s16 = 0; a16 = 0; wd16 = 0;

    vecs.push_back(mk(1, 2'b00, 32'h4, 32'h11223344, 32'h0, 2, 1, 1, 32'h11223344, 0));
    vecs.push_back(mk(1, 2'b11, 32'h6, 32'h000000AB, 32'h0, 4, 3, 1, 32'h11AB3344, 0));
    vecs.push_back(mk(0, 2'b10, 32'h6, 32'h0, 32'h000011AB, 3, 0, 1, 32'h11AB3344, 0));
    vecs.push_back(mk(1, 2'b01, 32'h8, 32'hDEADBEEF, 32'h0, 2, 1, 2, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 2'b11, 32'h9, 32'h0, 32'h000000BE, 3, 0, -1, 32'h0, 0));
    vecs.push_back(mk(0, 2'b00, 32'h8, 32'h0, 32'hDEADBEEF, 3, 0, -1, 32'h0, 0));
    vecs.push_back(mk(1, 2'b10, 32'hA, 32'h12345678, 32'h0, 4, 3, 2, 32'h5678BEEF, 0));
    vecs.push_back(mk(0, 2'b11, 32'hB, 32'h0, 32'h00000056, 3, 0, -1, 32'h0, 0));
    vecs.push_back(mk(0, 2'b01, 32'h4, 32'h0, 32'h11AB3344, 3, 0, -1, 32'h0, 0));
`ifdef REFLET_RAM_RESP_MISALIGN_ERR_EN
    vecs.push_back(mk(0, 2'b10, 32'h5, 32'h0, 32'h0, 1, 0, -1, 32'h0, 1));
    vecs.push_back(mk(1, 2'b10, 32'hB, 32'hCAFE, 32'h0, 1, 0, 2, 32'h5678BEEF, 1));
    vecs.push_back(mk(0, 2'b00, 32'h8, 32'h0, 32'h5678BEEF, 3, 0, -1, 32'h0, 0));
`else
    vecs.push_back(mk(0, 2'b10, 32'h5, 32'h0, 32'h00003344, 3, 0, -1, 32'h0, 0));
    vecs.push_back(mk(1, 2'b10, 32'hB, 32'hCAFE, 32'h0, 4, 3, 2, 32'hCAFEBEEF, 0));
    vecs.push_back(mk(0, 2'b00, 32'h8, 32'h0, 32'hCAFEBEEF, 3, 0, -1, 32'h0, 0));
`endif
    vecs.push_back(mk(1, 2'b11, 32'h7, 32'hFFFFFF5A, 32'h0, 4, 3, 1, 32'h5AAB3344, 0));
    vecs.push_back(mk(0, 2'b11, 32'h7, 32'h0, 32'h0000005A, 3, 0, -1, 32'h0, 0));

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset asserted while a byte store sits in CAP.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'b11; req_addr = 32'h4; req_wdata = 32'h77;
    we_cyc = 0; rv_cyc = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 0;
      if (ram_we && we_cyc == 0) we_cyc = c;
      if (resp_valid && rv_cyc == 0) rv_cyc = c;
      if (c == 2) reset = 1'b0;
    end
    chk_reset_state("mid-store reset");
    reset = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      if (ram_we && we_cyc == 0) we_cyc = c;
      if (resp_valid && rv_cyc == 0) rv_cyc = c;
    end
    chk("mid-store reset ram_we", 64'(we_cyc), 64'd0);
    chk("mid-store reset resp_valid", 64'(rv_cyc), 64'd0);
    chk("mid-store reset ram word", 64'(mem32[1]), 64'h5AAB3344);

    // Back-to-back loads with req_valid held across the first response.
    @(negedge clk);
    req_valid = 1; req_write = 0; req_size = 2'b00; req_addr = 32'h4;
    e.rdata = 32'h5AAB3344; e.lat = 3; e.err = 0;
    sb.push_back(e);
    sb.push_back(e);
    rdy_log = '0; rv_log = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      rdy_log[c] = req_ready;
      rv_log[c] = resp_valid;
      if (resp_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("b2b rdata cyc%0d", c), 64'(resp_rdata), 64'(e.rdata));
        end else begin
          chk("b2b unexpected response", 64'd1, 64'd0);
        end
      end
      if (c == 5) req_valid = 0;
    end
    chk("b2b req_ready pattern", 64'(rdy_log), 64'(10'b1100010000));
    chk("b2b resp_valid pattern", 64'(rv_log), 64'(10'b0010001000));
    chk("b2b scoreboard drained", 64'(sb.size()), 64'd0);
    sb.delete();

    // 16-bit word: 16- and 32-bit stores are both full-width.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v16 = 1; w16 = 1;
      s16 = (k == 0) ? 2'b10 : 2'b01;
      a16 = (k == 0) ? 16'h8 : 16'hA;
      wd16 = (k == 0) ? 16'hBEEF : 16'hACE1;
      we_cyc = 0; rv_cyc = 0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c == 1) v16 = 0;
        if (we16 && we_cyc == 0) we_cyc = c;
        if (rv16 && rv_cyc == 0) rv_cyc = c;
      end
      chk($sformatf("w16 #%0d ram_we cycle", k), 64'(we_cyc), 64'd1);
      chk($sformatf("w16 #%0d resp cycle", k), 64'(rv_cyc), 64'd2);
      chk($sformatf("w16 #%0d ram word", k), 64'(mem16[4 + k]), (k == 0) ? 64'hBEEF : 64'hACE1);
      chk($sformatf("w16 #%0d resp_rdata", k), 64'(rd16), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
